aes_ark_state: RTL and testbench
================================

AES_ARK_STATE -- requirements
Module: aes_ark_state

Interface
REQ-001 Parameter NB, default 4: state columns (32-bit words); state width SW = 32*NB.
REQ-002 Parameter NR, default 10: round count (10/12/14 for AES-128/192/256); RW = $clog2(NR+1).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 in_valid  in  1  new block offered on text_in.
REQ-006 in_ready  out  1  block accepted when in_valid & in_ready.
REQ-007 text_in  in  SW  plaintext; byte r of column c at bits [SW-1-8*(4c+r) -: 8].
REQ-008 key_in  in  SW  round key for round key_rnd; same byte mapping.
REQ-009 key_rnd  out  RW  index of round key needed this cycle.
REQ-010 state_o  out  SW  current state, feeds external SubBytes/ShiftRows/MixColumns logic.
REQ-011 sa_next  in  SW  transformed state returned by round logic.
REQ-012 rnd_en  in  1  sa_next valid this cycle; round advances.
REQ-013 last_rnd  out  1  current round is NR (round logic skips MixColumns).
REQ-014 abort  in  1  synchronous abandon of current block.
REQ-015 out_valid  out  1  result available on state_o.
REQ-016 out_ready  in  1  consumer takes result when out_valid & out_ready.

Function
REQ-017 FSM states IDLE, RUN, DONE; in_ready = (FSM==IDLE); out_valid = (FSM==DONE).
REQ-018 IDLE, in_valid=1: state <= text_in ^ key_in (key_rnd=0), cnt <= 1, go RUN.
REQ-019 RUN, rnd_en=1: state <= sa_next ^ key_in, byte-wise for all 4*NB bytes; cnt++; if cnt==NR go DONE.
REQ-020 RUN, rnd_en=0: state and cnt hold; no stall limit.
REQ-021 key_rnd = cnt in all states; last_rnd = (FSM==RUN && cnt==NR).
REQ-022 DONE: state held; on out_ready=1 go IDLE, cnt <= 0; new block accepted no earlier than next cycle.
REQ-023 Latency with rnd_en tied high: out_valid asserted NR+1 cycles after the accept edge.
REQ-024 in_valid outside IDLE ignored; rnd_en outside RUN ignored; out_ready outside DONE ignored.
REQ-025 abort=1 in any state: next cycle FSM=IDLE, cnt=0, state unchanged; abort overrides rnd_en, in_valid, out_ready in the same cycle.
REQ-026 All XOR purely bitwise, no carries; no combinational path from sa_next or key_in to any output.

Reset
REQ-027 rst_n low: FSM=IDLE, cnt=0, state=0 immediately (asynchronous); thus in_ready=1, out_valid=0, last_rnd=0, key_rnd=0, state_o=0.
REQ-028 Reset mid-RUN or in DONE discards the block; first post-reset accept behaves per REQ-018.

Structure
REQ-029 Package aes_pkg holds NB/NR defaults, typedef ark_fsm_e {IDLE,RUN,DONE}, and the state byte-index helper.
REQ-030 One sub-module aes_ark_lane: 8-bit register with load/round mux and XOR, instantiated 4*NB times via generate; FSM and counter in parent.

Verification
REQ-031 NR=10, text_in=00112233445566778899aabbccddeeff, key_in=000102030405060708090a0b0c0d0e0f, in_valid 1 cycle -> state_o=00102030405060708090a0b0c0d0e0f0, key_rnd=1, FSM=RUN.
REQ-032 rnd_en high 10 cycles with sa_next/key_in from the FIPS-197 C.1 trace -> out_valid at cycle 11, state_o=69c4e0d86a7b0430d8cdb78070b4c55a, last_rnd high only on 10th round.
REQ-033 rnd_en toggled 1-0-0-1 pattern -> cnt advances only on high cycles; state_o unchanged on low cycles.
REQ-034 out_ready held low 5 cycles in DONE -> out_valid and state_o stable, in_ready=0; in_valid ignored; out_ready=1 -> IDLE next cycle.
REQ-035 abort asserted with rnd_en=1 at cnt=4 -> next cycle IDLE, cnt=0, state_o unchanged; rst_n pulsed mid-RUN -> all outputs at reset values without a clock edge.
REQ-036 NB=8, NR=14 build: 256-bit load XOR of all-ones text with all-zero key -> state_o all ones; out_valid after 15 cycles.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES AddRoundKey state register: defaults, FSM encoding and
// the byte placement helper used to map (column, row) onto the flat state vector.
package aes_pkg;

  localparam int unsigned NbDefault = 4;
  localparam int unsigned NrDefault = 10;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } ark_fsm_e;

  // Byte r of column c sits MSB-first: bits [sw-1-8*(4c+r) -: 8].
  function automatic int unsigned byte_msb(input int unsigned sw, input int unsigned col,
                                           input int unsigned row);
    return sw - 1 - 8 * (4 * col + row);
  endfunction

endpackage

// File: rtl/aes_ark_lane.sv
// One byte of the AES state: loads text^key on block accept, sa^key on each round,
// otherwise holds.
module aes_ark_lane (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic       rnd_i,
  input  logic [7:0] text_i,
  input  logic [7:0] sa_i,
  input  logic [7:0] key_i,
  output logic [7:0] q_o
);

  logic [7:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (load_i) begin
      q_d = text_i ^ key_i;
    end else if (rnd_i) begin
      q_d = sa_i ^ key_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= 8'h00;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/aes_ark_state.sv
// AES state register with AddRoundKey: sequences the round counter and merges the
// externally computed round transform with the current round key.
module aes_ark_state
  import aes_pkg::*;
#(
  parameter int unsigned NB = NbDefault,
  parameter int unsigned NR = NrDefault,
  localparam int unsigned SW = 32 * NB,
  localparam int unsigned RW = $clog2(NR + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [SW-1:0] text_in,
  input  logic [SW-1:0] key_in,
  output logic [RW-1:0] key_rnd,
  output logic [SW-1:0] state_o,
  input  logic [SW-1:0] sa_next,
  input  logic          rnd_en,
  output logic          last_rnd,
  input  logic          abort,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [RW-1:0] NrCnt = RW'(NR);

  ark_fsm_e      fsm_q;
  logic [RW-1:0] cnt_q;
  logic [SW-1:0] state_w;
  logic          load;
  logic          rnd;

  // Abort wins over every other strobe and leaves the state bytes untouched.
  assign load = (fsm_q == IDLE) && in_valid && !abort;
  assign rnd  = (fsm_q == RUN) && rnd_en && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
    end else if (abort) begin
      fsm_q <= IDLE;
      cnt_q <= '0;
    end else begin
      unique case (fsm_q)
        IDLE: begin
          if (in_valid) begin
            fsm_q <= RUN;
            cnt_q <= RW'(1);
          end
        end
        RUN: begin
          if (rnd_en) begin
            cnt_q <= cnt_q + RW'(1);
            if (cnt_q == NrCnt) begin
              fsm_q <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            fsm_q <= IDLE;
            cnt_q <= '0;
          end
        end
        default: begin
          fsm_q <= IDLE;
          cnt_q <= '0;
        end
      endcase
    end
  end

  for (genvar b = 0; b < 4 * NB; b++) begin : g_lane
    localparam int unsigned Msb = byte_msb(SW, b / 4, b % 4);
    aes_ark_lane u_lane (
      .clk    (clk),
      .rst_n  (rst_n),
      .load_i (load),
      .rnd_i  (rnd),
      .text_i (text_in[Msb -: 8]),
      .sa_i   (sa_next[Msb -: 8]),
      .key_i  (key_in[Msb -: 8]),
      .q_o    (state_w[Msb -: 8])
    );
  end

  assign state_o   = state_w;
  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign key_rnd   = cnt_q;
  assign last_rnd  = (fsm_q == RUN) && (cnt_q == NrCnt);

endmodule

// File: tb/tb_aes_ark_state.sv
// Bench for aes_ark_state: FIPS-197 C.1 round trace, stall/abort/reset directed cases,
// and a 256-bit / 14-round build; finished blocks are checked through a scoreboard.
module tb_aes_ark_state;

  localparam logic [127:0] Pt      = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] Pt2     = 128'hffeeddccbbaa99887766554433221100;
  localparam logic [127:0] Load0   = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] R1Start = 128'h89d810e8855ace682d1843d8cb128fe4;
  localparam logic [127:0] Final   = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic [127:0] rk [11] = '{
    128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
    128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
    128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
    128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
    128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
    128'h13111d7fe3944a17f307a78b4d2b30c5};
  // Round-logic output (MixColumns, or ShiftRows for the last round) per round.
  logic [127:0] sa [11] = '{
    128'h0,
    128'h5f72641557f5bc92f7be3b291db9f91a, 128'hff87968431d86a51645151fa773ad009,
    128'h4c9c1e66f771f0762c3f868e534df256, 128'h6385b79ffc538df997be478e7547d691,
    128'hf4bcd45432e554d075f1d6c51dd03b3c, 128'h9816ee7400f87f556b2c049c8e5ad036,
    128'hc57e1c159a9bd286f05f4be098c63439, 128'hbaa03de7a1f9b56ed5512cba5f414d23,
    128'he9f74eec023020f61bf2ccf2353c21c7, 128'h7ad5fda789ef4e272bca100b3d9ff59f};

  logic         clk, rst_n;
  logic         in_valid, in_ready, rnd_en, last_rnd, abort, out_valid, out_ready;
  logic [127:0] text_in, key_in, state_o, sa_next;
  logic [3:0]   key_rnd;

  logic         b_in_valid, b_in_ready, b_rnd_en, b_last_rnd, b_abort, b_out_valid, b_out_ready;
  logic [255:0] b_text_in, b_key_in, b_state_o, b_sa_next;
  logic [3:0]   b_key_rnd;

  int checks = 0;
  int failures = 0;
  int n_out = 0;
  logic [127:0] sb_q [$];

  aes_ark_state #(.NB(4), .NR(10)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .text_in   (text_in),
    .key_in    (key_in),
    .key_rnd   (key_rnd),
    .state_o   (state_o),
    .sa_next   (sa_next),
    .rnd_en    (rnd_en),
    .last_rnd  (last_rnd),
    .abort     (abort),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  aes_ark_state #(.NB(8), .NR(14)) u_dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .text_in   (b_text_in),
    .key_in    (b_key_in),
    .key_rnd   (b_key_rnd),
    .state_o   (b_state_o),
    .sa_next   (b_sa_next),
    .rnd_en    (b_rnd_en),
    .last_rnd  (b_last_rnd),
    .abort     (b_abort),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: compares each result as it is handed to the consumer.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got %h expected no result", state_o);
      end else begin
        chk("sb_result", 256'(state_o), 256'(sb_q.pop_front()));
        n_out++;
      end
    end
  end

  initial begin
    int ncyc;
    int r;
    int pat [4] = '{1, 0, 0, 1};
    logic [127:0] hold_s;

    rst_n = 1'b0;
    in_valid = 1'b0; rnd_en = 1'b0; abort = 1'b0; out_ready = 1'b0;
    text_in = '0; key_in = '0; sa_next = '0;
    b_in_valid = 1'b0; b_rnd_en = 1'b0; b_abort = 1'b0; b_out_ready = 1'b0;
    b_text_in = '0; b_key_in = '0; b_sa_next = '0;
    #2;
    chk("rst_in_ready", 256'(in_ready), 256'(1));
    chk("rst_out_valid", 256'(out_valid), 256'(0));
    chk("rst_key_rnd", 256'(key_rnd), 256'(0));
    chk("rst_state", 256'(state_o), 256'(0));
    @(posedge clk);
    #1 rst_n = 1'b1;

    // FIPS-197 C.1 block, one round per cycle
    text_in = Pt; key_in = rk[0]; in_valid = 1'b1;
    step(); ncyc = 1;
    in_valid = 1'b0;
    sb_q.push_back(Final);
    chk("load_state", 256'(state_o), 256'(Load0));
    chk("load_key_rnd", 256'(key_rnd), 256'(1));
    chk("load_in_ready", 256'(in_ready), 256'(0));
    for (int i = 1; i <= 10; i++) begin
      sa_next = sa[i]; key_in = rk[i]; rnd_en = 1'b1;
      chk("last_rnd", 256'(last_rnd), 256'(i == 10));
      chk("key_rnd", 256'(key_rnd), 256'(i));
      chk("out_valid_early", 256'(out_valid), 256'(0));
      step(); ncyc++;
      if (i == 1) chk("round1_start", 256'(state_o), 256'(R1Start));
      if (i < 10) chk("round_state", 256'(state_o), 256'(sa[i] ^ rk[i]));
    end
    rnd_en = 1'b0;
    chk("done_out_valid", 256'(out_valid), 256'(1));
    chk("latency_nr10", 256'(ncyc), 256'(11));
    chk("final_state", 256'(state_o), 256'(Final));
    chk("done_last_rnd", 256'(last_rnd), 256'(0));

    // DONE stall with in_valid offered
    in_valid = 1'b1; text_in = Pt2;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("stall_out_valid", 256'(out_valid), 256'(1));
      chk("stall_state", 256'(state_o), 256'(Final));
      chk("stall_in_ready", 256'(in_ready), 256'(0));
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("release_in_ready", 256'(in_ready), 256'(1));
    chk("release_out_valid", 256'(out_valid), 256'(0));
    chk("release_key_rnd", 256'(key_rnd), 256'(0));
    chk("release_state_held", 256'(state_o), 256'(Final));

    // rnd_en 1-0-0-1 then abort at cnt 4
    text_in = Pt2; key_in = rk[0]; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("load2_state", 256'(state_o), 256'(Pt2 ^ rk[0]));
    r = 1;
    for (int p = 0; p < 4; p++) begin
      sa_next = sa[r]; key_in = rk[r]; rnd_en = (pat[p] == 1);
      hold_s = state_o;
      step();
      if (pat[p] == 1) begin
        chk("toggle_state_hi", 256'(state_o), 256'(sa[r] ^ rk[r]));
        r++;
      end else begin
        chk("toggle_state_lo", 256'(state_o), 256'(hold_s));
      end
      chk("toggle_key_rnd", 256'(key_rnd), 256'(r));
    end
    sa_next = sa[3]; key_in = rk[3]; rnd_en = 1'b1;
    step();
    chk("pre_abort_cnt", 256'(key_rnd), 256'(4));
    hold_s = state_o;
    sa_next = sa[4]; key_in = rk[4]; abort = 1'b1; in_valid = 1'b1;
    step();
    abort = 1'b0; rnd_en = 1'b0; in_valid = 1'b0;
    chk("abort_in_ready", 256'(in_ready), 256'(1));
    chk("abort_key_rnd", 256'(key_rnd), 256'(0));
    chk("abort_state", 256'(state_o), 256'(hold_s));
    chk("abort_out_valid", 256'(out_valid), 256'(0));

    // Asynchronous reset in the middle of a block
    text_in = Pt; key_in = rk[0]; in_valid = 1'b1;
    step();
    in_valid = 1'b0; sa_next = sa[1]; key_in = rk[1]; rnd_en = 1'b1;
    step();
    rnd_en = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", 256'(in_ready), 256'(1));
    chk("arst_out_valid", 256'(out_valid), 256'(0));
    chk("arst_last_rnd", 256'(last_rnd), 256'(0));
    chk("arst_key_rnd", 256'(key_rnd), 256'(0));
    chk("arst_state", 256'(state_o), 256'(0));
    step();
    rst_n = 1'b1;
    text_in = Pt; key_in = rk[0]; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    sb_q.push_back(Final);
    chk("post_rst_load", 256'(state_o), 256'(Load0));
    for (int i = 1; i <= 10; i++) begin
      sa_next = sa[i]; key_in = rk[i]; rnd_en = 1'b1;
      step();
    end
    rnd_en = 1'b0;
    chk("post_rst_done", 256'(out_valid), 256'(1));
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk("post_rst_idle", 256'(in_ready), 256'(1));

    // 256-bit state, 14 rounds, rnd_en tied high
    b_text_in = '1; b_key_in = '0; b_sa_next = '1; b_rnd_en = 1'b1; b_in_valid = 1'b1;
    step(); ncyc = 1;
    b_in_valid = 1'b0;
    chk("w_load_state", b_state_o, {256{1'b1}});
    while (!b_out_valid && ncyc < 40) begin
      step(); ncyc++;
    end
    chk("w_latency_nr14", 256'(ncyc), 256'(15));
    chk("w_final_state", b_state_o, {256{1'b1}});
    b_out_ready = 1'b1;
    step();
    b_out_ready = 1'b0; b_rnd_en = 1'b0;
    chk("w_idle", 256'(b_in_ready), 256'(1));

    chk("sb_results_seen", 256'(n_out), 256'(2));
    chk("sb_drained", 256'(sb_q.size()), 256'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
